// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, issues one-outstanding imem requests, latches the word into IR for decode.
// Latency: request accepted in cycle N, response in N+k -> if_valid in N+k+1; no overlap (best case 1 instr / 3 cycles).
// Backpressure: IR held stable while if_ready is low; IF_PERF_CNT_EN adds fetch/stall performance counters.
module instr_fetch_unit #(
    parameter int unsigned    XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output logic [6:0]      if_opcode,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetchState_t;

    fetchState_t     state;
    logic [XLEN-1:0] pc;
    logic            kill;
    logic            reqValidQ;
    logic            ifValidQ;
    logic [XLEN-1:0] ifPcQ;
    logic [XLEN-1:0] irQ;
    logic [XLEN-1:0] redirectPc;
    logic            unusedTargetBits;

    assign redirectPc       = {redirect_target[XLEN-1:2], 2'b00};
    assign unusedTargetBits = ^redirect_target[1:0];

    assign imem_req_valid = reqValidQ;
    assign imem_addr      = pc;
    assign if_valid       = ifValidQ;
    assign if_pc          = ifPcQ;
    assign if_instr       = irQ;
    assign if_opcode      = irQ[6:0];

    // Redirect wins over every other event; kill marks the in-flight word as stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BOOT;
            pc        <= RESET_PC;
            kill      <= 1'b0;
            reqValidQ <= 1'b0;
            ifValidQ  <= 1'b0;
            ifPcQ     <= RESET_PC;
            irQ       <= '0;
        end else begin
            case (state)
                BOOT: begin
                    if (redirect_valid) pc <= redirectPc;
                    state     <= REQ;
                    reqValidQ <= 1'b1;
                end
                REQ: begin
                    if (redirect_valid) pc <= redirectPc;
                    if (imem_req_ready) begin
                        state     <= WAIT;
                        reqValidQ <= 1'b0;
                        kill      <= redirect_valid;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        pc <= redirectPc;
                        if (imem_rsp_valid) begin
                            kill      <= 1'b0;
                            state     <= REQ;
                            reqValidQ <= 1'b1;
                        end else begin
                            kill <= 1'b1;
                        end
                    end else if (imem_rsp_valid) begin
                        if (kill) begin
                            kill      <= 1'b0;
                            state     <= REQ;
                            reqValidQ <= 1'b1;
                        end else begin
                            irQ      <= imem_rsp_data;
                            ifPcQ    <= pc;
                            ifValidQ <= 1'b1;
                            state    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        ifValidQ  <= 1'b0;
                        pc        <= redirectPc;
                        state     <= REQ;
                        reqValidQ <= 1'b1;
                    end else if (if_ready) begin
                        ifValidQ  <= 1'b0;
                        pc        <= pc + XLEN'(4);
                        state     <= REQ;
                        reqValidQ <= 1'b1;
                    end
                end
                default: begin
                    state     <= BOOT;
                    reqValidQ <= 1'b0;
                end
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (ifValidQ && if_ready)  perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (ifValidQ && !if_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`else
    // Counters compiled out: no extra ports or state.
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: expected (pc, instr) pairs queued when a live response is driven, popped when decode sees if_valid.
module tb_instr_fetch_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_instr;
    logic [6:0]      if_opcode;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
`ifdef IF_PERF_CNT_EN
    logic [31:0]     perf_fetch_cnt;
    logic [31:0]     perf_stall_cnt;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } expItem_t;

    expItem_t expQ[$];
    int       vecCnt  = 0;
    int       missCnt = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.XLEN(XLEN), .RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_pc           (if_pc),
        .if_instr        (if_instr),
        .if_opcode       (if_opcode),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_stall_cnt  (perf_stall_cnt)
`endif
    );

    task automatic checkVec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCnt++;
        if (obs !== exp) begin
            missCnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitReq(input string tag);
        for (int n = 0; n < 20 && !imem_req_valid; n++) tick();
        checkVec(tag, {31'b0, imem_req_valid}, 32'd1);
    endtask

    task automatic acceptReq(input logic [31:0] addr);
        waitReq("reqSeen");
        checkVec("reqAddr", imem_addr, addr);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        checkVec("reqDropInWait", {31'b0, imem_req_valid}, 32'd0);
    endtask

    task automatic respond(input logic [31:0] data, input logic live, input logic [31:0] pc);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        if (live) expQ.push_back('{pc: pc, instr: data});
        tick();
        imem_rsp_valid = 1'b0;
    endtask

    task automatic expectOut();
        expItem_t e;
        checkVec("ifValid", {31'b0, if_valid}, 32'd1);
        if (expQ.size() == 0) begin
            checkVec("sbUnderflow", 32'd1, {31'b0, if_valid} ^ 32'd1);
        end else if (if_valid) begin
            e = expQ.pop_front();
            checkVec("ifPc", if_pc, e.pc);
            checkVec("ifInstr", if_instr, e.instr);
            checkVec("ifOpcode", {25'b0, if_opcode}, {25'b0, e.instr[6:0]});
        end
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int lat);
        acceptReq(addr);
        for (int i = 1; i < lat; i++) begin
            checkVec("noIfWhileWait", {31'b0, if_valid}, 32'd0);
            tick();
        end
        respond(data, 1'b1, addr);
        expectOut();
    endtask

    task automatic consume();
        if_ready = 1'b1;
        tick();
        if_ready = 1'b0;
        checkVec("ifValidDrop", {31'b0, if_valid}, 32'd0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkVec({tag, "ReqValid"}, {31'b0, imem_req_valid}, 32'd0);
        checkVec({tag, "Addr"}, imem_addr, 32'h0);
        checkVec({tag, "IfValid"}, {31'b0, if_valid}, 32'd0);
        checkVec({tag, "IfPc"}, if_pc, 32'h0);
        checkVec({tag, "IfInstr"}, if_instr, 32'h0);
        checkVec({tag, "Opcode"}, {25'b0, if_opcode}, 32'h0);
    endtask

    initial begin
        logic [31:0] heldPc;
        logic [31:0] heldInstr;
        rst_n           = 1'b0;
        imem_req_ready  = 1'b0;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = '0;
        if_ready        = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        repeat (3) tick();
        checkResetOutputs("rst");

        // Release: one BOOT cycle, then REQ at RESET_PC.
        rst_n = 1'b1;
        checkVec("bootIdle", {31'b0, imem_req_valid}, 32'd0);
        tick();
        fetch(32'h0000_0000, 32'h0000_0033, 1);
        consume();
        waitReq("reqAfterFirst");
        checkVec("nextAddr4", imem_addr, 32'h0000_0004);

        // Decode stalls 5 cycles: IR and PC stable, no new request.
        fetch(32'h0000_0004, 32'h00A0_0093, 2);
        heldPc    = if_pc;
        heldInstr = if_instr;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkVec("stallValid", {31'b0, if_valid}, 32'd1);
            checkVec("stallInstr", if_instr, heldInstr);
            checkVec("stallPc", if_pc, heldPc);
            checkVec("stallNoReq", {31'b0, imem_req_valid}, 32'd0);
        end
`ifdef IF_PERF_CNT_EN
        checkVec("perfStall", perf_stall_cnt, 32'd5);
        checkVec("perfFetch", perf_fetch_cnt, 32'd1);
`endif
        consume();
        waitReq("reqAfterStall");
        checkVec("addrAfterStall", imem_addr, 32'h0000_0008);

        // Redirect while waiting: the stale word must never surface.
        acceptReq(32'h0000_0008);
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        checkVec("killNoIf", {31'b0, if_valid}, 32'd0);
        respond(32'h0000_0003, 1'b0, 32'h0);
        checkVec("staleDropped", {31'b0, if_valid}, 32'd0);
        checkVec("redirReq", {31'b0, imem_req_valid}, 32'd1);
        checkVec("redirAddr", imem_addr, 32'h0000_0100);
        fetch(32'h0000_0100, 32'h0000_0063, 1);
        consume();

        // Redirect coincident with the response.
        acceptReq(32'h0000_0104);
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0200;
        respond(32'h0000_0007, 1'b0, 32'h0);
        redirect_valid = 1'b0;
        checkVec("sameCycDrop", {31'b0, if_valid}, 32'd0);
        checkVec("sameCycReq", {31'b0, imem_req_valid}, 32'd1);
        checkVec("sameCycAddr", imem_addr, 32'h0000_0200);
        fetch(32'h0000_0200, 32'h0000_0017, 1);
        consume();

        // Redirect of an unaccepted request, then PC wrap at the top of memory.
        waitReq("reqBeforeWrap");
        checkVec("preWrapAddr", imem_addr, 32'h0000_0204);
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        checkVec("reqRedirStay", {31'b0, imem_req_valid}, 32'd1);
        fetch(32'hFFFF_FFFC, 32'h0000_006F, 1);
        consume();
        waitReq("reqAfterWrap");
        checkVec("wrapAddr", imem_addr, 32'h0000_0000);

        // Redirect in HOLD together with if_ready: target wins, no +4.
        fetch(32'h0000_0000, 32'h0000_0013, 1);
        if_ready        = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0302;
        tick();
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        checkVec("holdRedirDrop", {31'b0, if_valid}, 32'd0);
        checkVec("holdRedirAddr", imem_addr, 32'h0000_0300);
        fetch(32'h0000_0300, 32'hABCD_E0B7, 3);
        consume();

        // Reset while a response is outstanding.
        acceptReq(32'h0000_0304);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("midRst");
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        rst_n = 1'b1;
        tick();
        imem_rsp_valid = 1'b0;
        checkVec("postRstNoIf", {31'b0, if_valid}, 32'd0);
        checkVec("postRstInstr", if_instr, 32'h0);
        checkVec("postRstReq", {31'b0, imem_req_valid}, 32'd1);
        fetch(32'h0000_0000, 32'h0000_0033, 1);
        consume();

        checkVec("sbEmpty", expQ.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the control unit.
- Holds the PC and issues one-outstanding requests to instruction memory over a valid/ready request plus valid response interface.
- Captures the returned word into the instruction register (IR) and presents it to decode with a valid/ready handshake.
- if_opcode (IR[6:0]) drives the control unit's OpCode input; branch redirects from execute re-steer the PC.

Parameters:
XLEN, 32, width of PC, addresses and instruction word
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_addr  output  XLEN  fetch address, word aligned
imem_rsp_valid  input  1  response data valid, exactly one per accepted request
imem_rsp_data  input  XLEN  fetched instruction word
if_valid  output  1  IR holds a valid instruction for decode
if_ready  input  1  decode consumes the instruction this cycle
if_pc  output  XLEN  PC of the instruction in IR
if_instr  output  XLEN  instruction register
if_opcode  output  7  if_instr[6:0], to control unit OpCode
redirect_valid  input  1  taken branch/jump, single-cycle pulse
redirect_target  input  XLEN  new PC

Behaviour:
- Reset (asynchronous, active-low):
  - pc=RESET_PC, state=BOOT, kill=0.
  - Outputs: imem_req_valid=0, imem_addr=RESET_PC, if_valid=0, if_pc=RESET_PC, if_instr=0, if_opcode=7'b0000000 (control unit decodes this to all controls 0).
- FSM states: BOOT, REQ, WAIT, HOLD.
  - BOOT: one idle cycle after rst_n deasserts -> REQ.
  - REQ: imem_req_valid=1, imem_addr=pc. On imem_req_ready -> WAIT.
  - WAIT: imem_req_valid=0. On imem_rsp_valid:
    - kill=0: IR<=imem_rsp_data, if_pc<=pc, if_valid<=1 -> HOLD.
    - kill=1: discard the word, kill<=0 -> REQ.
  - HOLD: if_valid=1; IR and if_pc are stable while if_ready=0. On if_ready: if_valid<=0, pc<=pc+4 -> REQ.
- Latency: request accepted in cycle N, response in cycle N+k -> if_valid high in cycle N+k+1. Best-case throughput is one instruction per 3 cycles; no overlap.
- PC arithmetic: pc+4 is modulo 2^XLEN (0xFFFF_FFFC wraps to 0x0000_0000). redirect_target[1:0] is forced to 2'b00.
- Redirect has priority over all other events:
  - In REQ, not accepted: pc<=target, stay in REQ; the address may change while the request is unaccepted.
  - In REQ, accepted the same cycle: pc<=target, kill<=1 -> WAIT.
  - In WAIT: pc<=target, kill<=1. If imem_rsp_valid arrives in the same cycle, that word is discarded and the FSM goes directly to REQ with kill=0.
  - In HOLD: if_valid<=0, pc<=target -> REQ. If if_ready is high in the same cycle, the IR counts as consumed and pc still takes target (no +4).
  - In BOOT: pc<=target; BOOT still lasts one cycle.
- Responses are ignored in BOOT, REQ and HOLD.
- Reset mid-operation: immediate return to reset values; any outstanding response is ignored because the FSM is in BOOT.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- When defined: adds output ports perf_fetch_cnt (32) and perf_stall_cnt (32), both reset to 0.
  - perf_fetch_cnt increments on each if_valid && if_ready.
  - perf_stall_cnt increments on each cycle with if_valid && !if_ready.
  - Both wrap modulo 2^32.
- When undefined: neither port exists and there are no counter registers; all other behaviour is identical.

Test Plan:
- Reset release, memory always ready, 1-cycle response of 32'h0000_0033 -> first imem_addr=0x0; if_valid with if_opcode=7'b0110011 and if_pc=0x0; next request at 0x4.
- if_ready held low 5 cycles in HOLD -> if_instr/if_pc stable; no new request; pc unchanged; perf_stall_cnt=5 with IF_PERF_CNT_EN.
- redirect_valid with target 0x0000_0103 while in WAIT; stale response 0x0000_0003 arrives -> word dropped, never visible on if_valid; next imem_addr=0x0000_0100.
- redirect_valid in the same cycle as imem_rsp_valid -> response dropped; next cycle REQ at the target.
- PC=0xFFFF_FFFC consumed -> next imem_addr=0x0000_0000.
- rst_n asserted in WAIT with a response pending -> outputs at reset values immediately; the late imem_rsp_valid is ignored; fetch restarts at RESET_PC after BOOT.
